stream_demux: RTL and testbench
===============================

STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 SHALL provide parameter DW, default 8: payload width in bits (>=1).
REQ-002 SHALL provide parameter NCH, default 4: output channel count (2..16, non-power-of-two allowed).
REQ-003 SHALL provide derived localparam SW = max(1, clog2(NCH)): select width.
REQ-004 SHALL provide port clk  input  1  the single clock; all state rising-edge.
REQ-005 SHALL provide port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL provide port s_valid  input  1  upstream beat valid.
REQ-007 SHALL provide port s_ready  output  1  upstream beat accepted when s_valid & s_ready.
REQ-008 SHALL provide port s_data  input  DW  upstream payload.
REQ-009 SHALL provide port s_sel  input  SW  destination channel; sampled only on a packet's first beat.
REQ-010 SHALL provide port s_last  input  1  final beat of packet.
REQ-011 SHALL provide port m_valid  output  NCH  per-channel valid, at most one bit set.
REQ-012 SHALL provide port m_ready  input  NCH  per-channel ready.
REQ-013 SHALL provide port m_data  output  DW  shared payload bus, meaningful where m_valid set.
REQ-014 SHALL provide port m_last  output  1  shared last flag.
REQ-015 SHALL provide port drop_cnt  output  16  count of dropped packets, saturating.

Function
REQ-016 SHALL use one output register stage (data, last, dest, full); latency s-accept to m_valid = 1 cycle.
REQ-017 SHALL drive m_valid[k] = full & (dest == k); all other bits 0.
REQ-018 SHALL drive s_ready = !full | m_ready[dest] in ROUTE/IDLE (full throughput with backpressure passthrough); s_ready = 1 in DROP.
REQ-019 SHALL hold m_data/m_last/dest stable while full & !m_ready[dest].
REQ-020 SHALL implement FSM states IDLE (awaiting first beat), ROUTE (mid-packet, channel locked), DROP (mid-packet, discarding).
REQ-021 IDLE: on accepted beat with s_sel < NCH, lock chan = s_sel, load register; go ROUTE if !s_last, else stay IDLE.
REQ-022 IDLE: on accepted beat with s_sel >= NCH, discard beat, do not load register; go DROP if !s_last; if s_last stay IDLE; either way increment drop_cnt once.
REQ-023 ROUTE: each accepted beat loads register with dest = locked chan, ignoring s_sel; accepted s_last returns to IDLE.
REQ-024 DROP: accepts and discards every beat; accepted s_last returns to IDLE; drop_cnt not incremented again.
REQ-025 drop_cnt SHALL saturate at 16'hFFFF, never wrap.
REQ-026 Simultaneous output pop and input accept in same cycle SHALL leave full = 1 with new beat (no bubble).
REQ-027 s_sel changes mid-packet SHALL have no effect.

Reset
REQ-028 rst_n low SHALL immediately force: FSM IDLE, full 0, m_valid all 0, m_last 0, m_data 0, dest 0, drop_cnt 0; s_ready 1 combinationally.
REQ-029 Reset mid-packet SHALL abandon the packet; first beat after release is treated as a new packet's first beat.

Structure
REQ-030 SHALL place the FSM state enum (IDLE, ROUTE, DROP) and DROP_CNT_W = 16 in shared package stream_demux_pkg.
REQ-031 SHALL implement output stage as sub-module stream_demux_oreg (DW, SW parameters); FSM and counter stay in top.

Verification
REQ-032 NCH=4, DW=8: 3-beat packet sel=2 data 0x11,0x22,0x33, all m_ready=1 -> m_valid=4'b0100 on cycles t+1..t+3, m_last only with 0x33.
REQ-033 NCH=4: packet sel=1 with m_ready[1]=0 for 3 cycles -> s_ready=0, m_data held 0x11, no beat lost; release -> beats in order.
REQ-034 NCH=4: s_sel toggled 0->3 on beat 2 of sel=0 packet -> all beats to channel 0.
REQ-035 NCH=3: 2-beat packet sel=3 -> no m_valid, s_ready=1 throughout, drop_cnt 0->1; following sel=0 single beat routes normally.
REQ-036 rst_n pulsed low mid-packet while full -> m_valid=0 same cycle, drop_cnt=0; next beat sel=2 routes to channel 2.
REQ-037 Force drop_cnt path with 65536 single-beat bad packets (NCH=3) -> drop_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// rtl/stream_demux_pkg.sv - shared FSM state type and counter width for stream_demux
package stream_demux_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUTE = 2'd1,
      DROP  = 2'd2
   } state_t;

   localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/stream_demux_oreg.sv
// rtl/stream_demux_oreg.sv - single output register stage holding payload, last flag and destination
module stream_demux_oreg #(
   parameter int DW = 8,
   parameter int SW = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic          pop,
   input  logic [DW-1:0] in_data,
   input  logic          in_last,
   input  logic [SW-1:0] in_dest,
   output logic          full,
   output logic [DW-1:0] data,
   output logic          last,
   output logic [SW-1:0] dest
);

   // load takes priority over pop so a same-cycle pop+load leaves no bubble
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full <= 1'b0;
         data <= '0;
         last <= 1'b0;
         dest <= '0;
      end else if (load) begin
         full <= 1'b1;
         data <= in_data;
         last <= in_last;
         dest <= in_dest;
      end else if (pop) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/stream_demux.sv
// rtl/stream_demux.sv - packet-aware 1:NCH stream demux; out-of-range selects drop the whole packet
module stream_demux
   import stream_demux_pkg::*;
#(
   parameter  int DW  = 8,
   parameter  int NCH = 4,
   localparam int SW  = (NCH > 2) ? $clog2(NCH) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DW-1:0]         s_data,
   input  logic [SW-1:0]         s_sel,
   input  logic                  s_last,
   output logic [NCH-1:0]        m_valid,
   input  logic [NCH-1:0]        m_ready,
   output logic [DW-1:0]         m_data,
   output logic                  m_last,
   output logic [DROP_CNT_W-1:0] drop_cnt
);

   state_t        state;
   logic [SW-1:0] chan;
   logic          full;
   logic [SW-1:0] dest;
   logic          pop;
   logic          accept;
   logic          sel_ok;
   logic          load;
   logic          bad_first;

   always_comb begin
      m_valid = '0;
      for (int k = 0; k < NCH; k++) begin
         m_valid[k] = full && (int'(dest) == k);
      end
   end

   assign pop       = |(m_valid & m_ready);
   assign s_ready   = (state == DROP) || !full || pop;
   assign accept    = s_valid && s_ready;
   assign sel_ok    = int'(s_sel) < NCH;
   assign load      = accept && ((state == IDLE && sel_ok) || state == ROUTE);
   assign bad_first = accept && (state == IDLE) && !sel_ok;

   stream_demux_oreg #(
      .DW (DW),
      .SW (SW)
   ) u_oreg (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .pop     (pop),
      .in_data (s_data),
      .in_last (s_last),
      .in_dest ((state == ROUTE) ? chan : s_sel),
      .full    (full),
      .data    (m_data),
      .last    (m_last),
      .dest    (dest)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         chan  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (sel_ok) begin
                     chan <= s_sel;
                     if (!s_last) state <= ROUTE;
                  end else if (!s_last) begin
                     state <= DROP;
                  end
               end
            end
            ROUTE, DROP: begin
               if (accept && s_last) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // one count per dropped packet, taken on its first beat only
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt <= '0;
      end else if (bad_first && (drop_cnt != '1)) begin
         drop_cnt <= drop_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_stream_demux.sv
// tb/tb_stream_demux.sv - directed self-checking bench for stream_demux (NCH=4 and NCH=3 instances)
module tb_stream_demux;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        a_valid, a_ready, a_last, a_mlast;
   logic [7:0]  a_data, a_mdata;
   logic [1:0]  a_sel;
   logic [3:0]  a_mvalid, a_mready;
   logic [15:0] a_drop;

   logic        b_valid, b_ready, b_last, b_mlast;
   logic [7:0]  b_data, b_mdata;
   logic [1:0]  b_sel;
   logic [2:0]  b_mvalid, b_mready;
   logic [15:0] b_drop;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   stream_demux #(.DW(8), .NCH(4)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .s_valid(a_valid), .s_ready(a_ready), .s_data(a_data), .s_sel(a_sel), .s_last(a_last),
      .m_valid(a_mvalid), .m_ready(a_mready), .m_data(a_mdata), .m_last(a_mlast),
      .drop_cnt(a_drop)
   );

   stream_demux #(.DW(8), .NCH(3)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .s_valid(b_valid), .s_ready(b_ready), .s_data(b_data), .s_sel(b_sel), .s_last(b_last),
      .m_valid(b_mvalid), .m_ready(b_mready), .m_data(b_mdata), .m_last(b_mlast),
      .drop_cnt(b_drop)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic v, input logic [1:0] sel, input logic [7:0] d, input logic l);
      a_valid = v; a_sel = sel; a_data = d; a_last = l;
   endtask

   task automatic drive_b(input logic v, input logic [1:0] sel, input logic [7:0] d, input logic l);
      b_valid = v; b_sel = sel; b_data = d; b_last = l;
   endtask

   task automatic test_reset();
      #1;
      n_cmp++; if (a_mvalid !== 4'b0000) begin n_bad++; $display("FAIL reset_mvalid act=%b exp=0000", a_mvalid); end
      n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL reset_sready act=%b exp=1", a_ready); end
      n_cmp++; if (a_mdata !== 8'h00 || a_mlast !== 1'b0) begin n_bad++; $display("FAIL reset_data act=%h/%b exp=00/0", a_mdata, a_mlast); end
      n_cmp++; if (a_drop !== 16'd0 || b_drop !== 16'd0) begin n_bad++; $display("FAIL reset_drop act=%h/%h exp=0000", a_drop, b_drop); end
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_route();
      a_mready = 4'b1111;
      drive_a(1, 2'd2, 8'h11, 0);
      n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL route_sready act=%b exp=1", a_ready); end
      step();
      n_cmp++; if (a_mvalid !== 4'b0100 || a_mdata !== 8'h11 || a_mlast !== 1'b0) begin n_bad++; $display("FAIL route_b0 act=%b/%h/%b exp=0100/11/0", a_mvalid, a_mdata, a_mlast); end
      drive_a(1, 2'd2, 8'h22, 0);
      step();
      n_cmp++; if (a_mvalid !== 4'b0100 || a_mdata !== 8'h22 || a_mlast !== 1'b0) begin n_bad++; $display("FAIL route_b1 act=%b/%h/%b exp=0100/22/0", a_mvalid, a_mdata, a_mlast); end
      drive_a(1, 2'd2, 8'h33, 1);
      step();
      n_cmp++; if (a_mvalid !== 4'b0100 || a_mdata !== 8'h33 || a_mlast !== 1'b1) begin n_bad++; $display("FAIL route_b2 act=%b/%h/%b exp=0100/33/1", a_mvalid, a_mdata, a_mlast); end
      drive_a(0, 2'd0, 8'h00, 0);
      step();
      n_cmp++; if (a_mvalid !== 4'b0000) begin n_bad++; $display("FAIL route_drain act=%b exp=0000", a_mvalid); end
   endtask

   task automatic test_backpressure();
      a_mready = 4'b1101;
      drive_a(1, 2'd1, 8'h11, 0);
      step();
      n_cmp++; if (a_mvalid !== 4'b0010 || a_mdata !== 8'h11) begin n_bad++; $display("FAIL bp_first act=%b/%h exp=0010/11", a_mvalid, a_mdata); end
      drive_a(1, 2'd1, 8'h22, 0);
      for (int i = 0; i < 3; i++) begin
         n_cmp++; if (a_ready !== 1'b0 || a_mdata !== 8'h11 || a_mvalid !== 4'b0010) begin n_bad++; $display("FAIL bp_hold%0d act=%b/%h/%b exp=0/11/0010", i, a_ready, a_mdata, a_mvalid); end
         step();
      end
      a_mready = 4'b1111;
      #1;
      n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release act=%b exp=1", a_ready); end
      step();
      n_cmp++; if (a_mvalid !== 4'b0010 || a_mdata !== 8'h22) begin n_bad++; $display("FAIL bp_b1 act=%b/%h exp=0010/22", a_mvalid, a_mdata); end
      drive_a(1, 2'd1, 8'h33, 1);
      step();
      n_cmp++; if (a_mvalid !== 4'b0010 || a_mdata !== 8'h33 || a_mlast !== 1'b1) begin n_bad++; $display("FAIL bp_b2 act=%b/%h/%b exp=0010/33/1", a_mvalid, a_mdata, a_mlast); end
      drive_a(0, 2'd0, 8'h00, 0);
      step();
      n_cmp++; if (a_mvalid !== 4'b0000) begin n_bad++; $display("FAIL bp_drain act=%b exp=0000", a_mvalid); end
   endtask

   task automatic test_sel_change();
      a_mready = 4'b1111;
      drive_a(1, 2'd0, 8'hA0, 0);
      step();
      n_cmp++; if (a_mvalid !== 4'b0001 || a_mdata !== 8'hA0) begin n_bad++; $display("FAIL sel_b0 act=%b/%h exp=0001/a0", a_mvalid, a_mdata); end
      drive_a(1, 2'd3, 8'hA1, 0);
      step();
      n_cmp++; if (a_mvalid !== 4'b0001 || a_mdata !== 8'hA1) begin n_bad++; $display("FAIL sel_b1 act=%b/%h exp=0001/a1", a_mvalid, a_mdata); end
      drive_a(1, 2'd3, 8'hA2, 1);
      step();
      n_cmp++; if (a_mvalid !== 4'b0001 || a_mdata !== 8'hA2 || a_mlast !== 1'b1) begin n_bad++; $display("FAIL sel_b2 act=%b/%h/%b exp=0001/a2/1", a_mvalid, a_mdata, a_mlast); end
      drive_a(0, 2'd0, 8'h00, 0);
      step();
   endtask

   task automatic test_mid_reset();
      a_mready = 4'b0000;
      drive_a(1, 2'd1, 8'h44, 0);
      step();
      drive_a(0, 2'd0, 8'h00, 0);
      n_cmp++; if (a_mvalid !== 4'b0010) begin n_bad++; $display("FAIL mr_full act=%b exp=0010", a_mvalid); end
      rst_n = 1'b0;
      #1;
      n_cmp++; if (a_mvalid !== 4'b0000 || a_drop !== 16'd0 || a_ready !== 1'b1 || a_mdata !== 8'h00) begin n_bad++; $display("FAIL mr_async act=%b/%h/%b/%h exp=0000/0000/1/00", a_mvalid, a_drop, a_ready, a_mdata); end
      step();
      rst_n = 1'b1;
      a_mready = 4'b1111;
      drive_a(1, 2'd2, 8'h77, 1);
      step();
      n_cmp++; if (a_mvalid !== 4'b0100 || a_mdata !== 8'h77 || a_mlast !== 1'b1) begin n_bad++; $display("FAIL mr_new act=%b/%h/%b exp=0100/77/1", a_mvalid, a_mdata, a_mlast); end
      drive_a(0, 2'd0, 8'h00, 0);
      step();
   endtask

   task automatic test_drop();
      b_mready = 3'b111;
      drive_b(1, 2'd3, 8'hAA, 0);
      n_cmp++; if (b_ready !== 1'b1) begin n_bad++; $display("FAIL drop_sready0 act=%b exp=1", b_ready); end
      step();
      n_cmp++; if (b_mvalid !== 3'b000 || b_drop !== 16'd1) begin n_bad++; $display("FAIL drop_b0 act=%b/%h exp=000/0001", b_mvalid, b_drop); end
      drive_b(1, 2'd0, 8'hBB, 1);
      n_cmp++; if (b_ready !== 1'b1) begin n_bad++; $display("FAIL drop_sready1 act=%b exp=1", b_ready); end
      step();
      n_cmp++; if (b_mvalid !== 3'b000 || b_drop !== 16'd1) begin n_bad++; $display("FAIL drop_b1 act=%b/%h exp=000/0001", b_mvalid, b_drop); end
      drive_b(1, 2'd0, 8'h5A, 1);
      step();
      n_cmp++; if (b_mvalid !== 3'b001 || b_mdata !== 8'h5A || b_mlast !== 1'b1 || b_drop !== 16'd1) begin n_bad++; $display("FAIL drop_next act=%b/%h/%b/%h exp=001/5a/1/0001", b_mvalid, b_mdata, b_mlast, b_drop); end
      drive_b(0, 2'd0, 8'h00, 0);
      step();
   endtask

   task automatic test_saturate();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      drive_b(1, 2'd3, 8'hEE, 1);
      repeat (65534) @(posedge clk);
      #1;
      n_cmp++; if (b_drop !== 16'hFFFE) begin n_bad++; $display("FAIL sat_fffe act=%h exp=fffe", b_drop); end
      step();
      n_cmp++; if (b_drop !== 16'hFFFF) begin n_bad++; $display("FAIL sat_ffff act=%h exp=ffff", b_drop); end
      repeat (5) step();
      n_cmp++; if (b_drop !== 16'hFFFF || b_mvalid !== 3'b000) begin n_bad++; $display("FAIL sat_hold act=%h/%b exp=ffff/000", b_drop, b_mvalid); end
      drive_b(0, 2'd0, 8'h00, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      a_mready = 4'b0000;
      b_mready = 3'b000;
      drive_a(0, 2'd0, 8'h00, 0);
      drive_b(0, 2'd0, 8'h00, 0);
      test_reset();
      test_route();
      test_backpressure();
      test_sel_change();
      test_mid_reset();
      test_drop();
      test_saturate();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
